stopwatch_ctrl: RTL and testbench

- Sequencing controller for the stopwatch. It consumes the divided square-wave clocks from the clock divider (1 Hz, 2 Hz, blink), all in the master clock domain, plus the user buttons and switches.
- Runs a BCD MM:SS counter through three modes: RUN, PAUSED and ADJUST.
- Drives the digit values and per-field blank flags to the seven-segment display mux.
- All logic runs on the 100 MHz master clock. Divided clocks are used only as edge-detected enables, never as clocks.

---
 rtl/stopwatch_ctrl_if.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its environment:
// divided level clocks, user controls, and the display-facing digits/flags.
`timescale 1ns/1ps

interface stopwatch_ctrl_if;
    logic       clk1_lvl;
    logic       clk2_lvl;
    logic       blink_lvl;
    logic       pause_btn;
    logic       clr_btn;
    logic       adj_sw;
    logic       sel_sw;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blank_min;
    logic       blank_sec;
    logic       paused;

    modport master (
        output clk1_lvl, clk2_lvl, blink_lvl, pause_btn, clr_btn, adj_sw, sel_sw,
        input  min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, paused
    );

    modport slave (
        input  clk1_lvl, clk2_lvl, blink_lvl, pause_btn, clr_btn, adj_sw, sel_sw,
        output min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, paused
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: BCD MM:SS counter with RUN / PAUSED / ADJUST
// modes, driven by edge-detected divider levels and synchronized user controls.
`timescale 1ns/1ps

module stopwatch_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 59
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_ADJUST
    } state_t;

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

    logic [SYNC_STAGES-1:0] pause_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] adj_sync;
    logic [SYNC_STAGES-1:0] sel_sync;

    logic pause_prev;
    logic clr_prev;
    logic clk1_q;
    logic clk1_prev;
    logic clk2_q;
    logic clk2_prev;

    logic pause_s;
    logic clr_s;
    logic adj_s;
    logic sel_s;
    logic pause_pulse;
    logic clr_pulse;
    logic tick1;
    logic tick2;

    state_t state_q;
    state_t state_d;
    logic   paused_q;
    logic   paused_d;

    logic [3:0] min_t_q, min_o_q, sec_t_q, sec_o_q;
    logic [3:0] min_t_d, min_o_d, sec_t_d, sec_o_d;
    logic [3:0] min_t_inc, min_o_inc, sec_t_inc, sec_o_inc;
    logic       sec_wrap;

    logic blank_min_q;
    logic blank_sec_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_sync <= '0;
            clr_sync   <= '0;
            adj_sync   <= '0;
            sel_sync   <= '0;
            pause_prev <= 1'b0;
            clr_prev   <= 1'b0;
            clk1_q     <= 1'b0;
            clk1_prev  <= 1'b0;
            clk2_q     <= 1'b0;
            clk2_prev  <= 1'b0;
        end else begin
            pause_sync <= {pause_sync[SYNC_STAGES-2:0], bus.pause_btn};
            clr_sync   <= {clr_sync[SYNC_STAGES-2:0],   bus.clr_btn};
            adj_sync   <= {adj_sync[SYNC_STAGES-2:0],   bus.adj_sw};
            sel_sync   <= {sel_sync[SYNC_STAGES-2:0],   bus.sel_sw};
            pause_prev <= pause_s;
            clr_prev   <= clr_s;
            clk1_q     <= bus.clk1_lvl;
            clk1_prev  <= clk1_q;
            clk2_q     <= bus.clk2_lvl;
            clk2_prev  <= clk2_q;
        end
    end

    assign pause_s     = pause_sync[SYNC_STAGES-1];
    assign clr_s       = clr_sync[SYNC_STAGES-1];
    assign adj_s       = adj_sync[SYNC_STAGES-1];
    assign sel_s       = sel_sync[SYNC_STAGES-1];
    assign pause_pulse = pause_s & ~pause_prev;
    assign clr_pulse   = clr_s & ~clr_prev;
    assign tick1       = clk1_q & ~clk1_prev;
    assign tick2       = clk2_q & ~clk2_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
        end
    end

    // The paused flag survives a trip through ADJUST so we know where to return.
    always_comb begin
        state_d  = state_q;
        paused_d = paused_q;
        case (state_q)
            ST_RUN, ST_PAUSED: begin
                if (pause_pulse) begin
                    paused_d = ~paused_q;
                end
                if (adj_s) begin
                    state_d = ST_ADJUST;
                end else begin
                    state_d = paused_d ? ST_PAUSED : ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj_s) begin
                    state_d = paused_q ? ST_PAUSED : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        sec_wrap = (sec_t_q == 4'd5) && (sec_o_q == 4'd9);

        sec_o_inc = (sec_o_q == 4'd9) ? 4'd0 : sec_o_q + 4'd1;
        sec_t_inc = sec_t_q;
        if (sec_o_q == 4'd9) begin
            sec_t_inc = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
        end

        min_o_inc = min_o_q + 4'd1;
        min_t_inc = min_t_q;
        if ((min_t_q == MAX_MIN_TENS) && (min_o_q == MAX_MIN_ONES)) begin
            min_o_inc = 4'd0;
            min_t_inc = 4'd0;
        end else if (min_o_q == 4'd9) begin
            min_o_inc = 4'd0;
            min_t_inc = min_t_q + 4'd1;
        end
    end

    // Clear wins over any tick in the same cycle; adjust increments never carry.
    always_comb begin
        min_t_d = min_t_q;
        min_o_d = min_o_q;
        sec_t_d = sec_t_q;
        sec_o_d = sec_o_q;
        if (clr_pulse) begin
            min_t_d = 4'd0;
            min_o_d = 4'd0;
            sec_t_d = 4'd0;
            sec_o_d = 4'd0;
        end else if ((state_q == ST_RUN) && tick1) begin
            sec_t_d = sec_t_inc;
            sec_o_d = sec_o_inc;
            if (sec_wrap) begin
                min_t_d = min_t_inc;
                min_o_d = min_o_inc;
            end
        end else if ((state_q == ST_ADJUST) && tick2) begin
            if (sel_s) begin
                sec_t_d = sec_t_inc;
                sec_o_d = sec_o_inc;
            end else begin
                min_t_d = min_t_inc;
                min_o_d = min_o_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_t_q     <= 4'd0;
            min_o_q     <= 4'd0;
            sec_t_q     <= 4'd0;
            sec_o_q     <= 4'd0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            min_t_q     <= min_t_d;
            min_o_q     <= min_o_d;
            sec_t_q     <= sec_t_d;
            sec_o_q     <= sec_o_d;
            blank_min_q <= (state_q == ST_ADJUST) & bus.blink_lvl & ~sel_s;
            blank_sec_q <= (state_q == ST_ADJUST) & bus.blink_lvl & sel_s;
        end
    end

    assign bus.min_tens  = min_t_q;
    assign bus.min_ones  = min_o_q;
    assign bus.sec_tens  = sec_t_q;
    assign bus.sec_ones  = sec_o_q;
    assign bus.blank_min = blank_min_q;
    assign bus.blank_sec = blank_sec_q;
    assign bus.paused    = paused_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a table of operations with hand-derived
// expected display states, checked through a scoreboard queue, plus timing corners.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

    localparam int SYNC_STAGES = 2;

    typedef enum int {
        OP_T1, OP_T2, OP_PAUSE, OP_CLR, OP_ADJ_ON, OP_ADJ_OFF,
        OP_SEL0, OP_SEL1, OP_BLINK0, OP_BLINK1, OP_PAUSE_T1, OP_CLR_T1
    } op_t;

    typedef struct {
        op_t         op;
        int          rep;
        logic [15:0] digits;
        logic        paused;
        logic        bmin;
        logic        bsec;
    } vec_t;

    typedef struct packed {
        logic [15:0] digits;
        logic        paused;
        logic        bmin;
        logic        bsec;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    vec_t vecs[$];
    exp_t sb[$];

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .MAX_MINUTES(59)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic addVec(input op_t op, input int rep, input logic [15:0] d,
                          input logic p, input logic bm, input logic bs);
        vec_t v;
        v.op = op; v.rep = rep; v.digits = d; v.paused = p; v.bmin = bm; v.bsec = bs;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string what, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got empty scoreboard expected entry", name);
        end else begin
            e = sb.pop_front();
            cmp({name, ".digits"}, {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}, e.digits);
            cmp({name, ".paused"}, 16'(bus.paused), 16'(e.paused));
            cmp({name, ".blank_min"}, 16'(bus.blank_min), 16'(e.bmin));
            cmp({name, ".blank_sec"}, 16'(bus.blank_sec), 16'(e.bsec));
        end
    endtask

    // Combined ops line the button pulse up with the tick pulse in the same cycle.
    task automatic applyStimulus(input op_t op);
        case (op)
            OP_T1:      begin bus.clk1_lvl = 1'b1; cycles(4); bus.clk1_lvl = 1'b0; cycles(4); end
            OP_T2:      begin bus.clk2_lvl = 1'b1; cycles(4); bus.clk2_lvl = 1'b0; cycles(4); end
            OP_PAUSE:   begin bus.pause_btn = 1'b1; cycles(6); bus.pause_btn = 1'b0; cycles(6); end
            OP_CLR:     begin bus.clr_btn = 1'b1; cycles(6); bus.clr_btn = 1'b0; cycles(6); end
            OP_ADJ_ON:  begin bus.adj_sw = 1'b1; cycles(6); end
            OP_ADJ_OFF: begin bus.adj_sw = 1'b0; cycles(6); end
            OP_SEL0:    begin bus.sel_sw = 1'b0; cycles(6); end
            OP_SEL1:    begin bus.sel_sw = 1'b1; cycles(6); end
            OP_BLINK0:  begin bus.blink_lvl = 1'b0; cycles(4); end
            OP_BLINK1:  begin bus.blink_lvl = 1'b1; cycles(4); end
            OP_PAUSE_T1: begin
                bus.pause_btn = 1'b1; cycles(SYNC_STAGES - 1);
                bus.clk1_lvl = 1'b1; cycles(6);
                bus.pause_btn = 1'b0; bus.clk1_lvl = 1'b0; cycles(6);
            end
            OP_CLR_T1: begin
                bus.clr_btn = 1'b1; cycles(SYNC_STAGES - 1);
                bus.clk1_lvl = 1'b1; cycles(6);
                bus.clr_btn = 1'b0; bus.clk1_lvl = 1'b0; cycles(6);
            end
            default: cycles(1);
        endcase
    endtask

    initial begin
        addVec(OP_T1,       3,  16'h0003, 0, 0, 0);
        addVec(OP_SEL1,     1,  16'h0003, 0, 0, 0);
        addVec(OP_ADJ_ON,   1,  16'h0003, 0, 0, 0);
        addVec(OP_T1,       2,  16'h0003, 0, 0, 0);
        addVec(OP_T2,       56, 16'h0059, 0, 0, 0);
        addVec(OP_ADJ_OFF,  1,  16'h0059, 0, 0, 0);
        addVec(OP_T1,       1,  16'h0100, 0, 0, 0);
        addVec(OP_ADJ_ON,   1,  16'h0100, 0, 0, 0);
        addVec(OP_T2,       59, 16'h0159, 0, 0, 0);
        addVec(OP_SEL0,     1,  16'h0159, 0, 0, 0);
        addVec(OP_T2,       58, 16'h5959, 0, 0, 0);
        addVec(OP_ADJ_OFF,  1,  16'h5959, 0, 0, 0);
        addVec(OP_T1,       1,  16'h0000, 0, 0, 0);
        addVec(OP_T1,       5,  16'h0005, 0, 0, 0);
        addVec(OP_PAUSE,    1,  16'h0005, 1, 0, 0);
        addVec(OP_T1,       4,  16'h0005, 1, 0, 0);
        addVec(OP_PAUSE,    1,  16'h0005, 0, 0, 0);
        addVec(OP_T1,       1,  16'h0006, 0, 0, 0);
        addVec(OP_T1,       52, 16'h0058, 0, 0, 0);
        addVec(OP_SEL1,     1,  16'h0058, 0, 0, 0);
        addVec(OP_BLINK1,   1,  16'h0058, 0, 0, 0);
        addVec(OP_ADJ_ON,   1,  16'h0058, 0, 0, 1);
        addVec(OP_T2,       1,  16'h0059, 0, 0, 1);
        addVec(OP_T2,       1,  16'h0000, 0, 0, 1);
        addVec(OP_T2,       1,  16'h0001, 0, 0, 1);
        addVec(OP_T1,       3,  16'h0001, 0, 0, 1);
        addVec(OP_SEL0,     1,  16'h0001, 0, 1, 0);
        addVec(OP_BLINK0,   1,  16'h0001, 0, 0, 0);
        addVec(OP_ADJ_OFF,  1,  16'h0001, 0, 0, 0);
        addVec(OP_T1,       9,  16'h0010, 0, 0, 0);
        addVec(OP_PAUSE_T1, 1,  16'h0011, 1, 0, 0);
        addVec(OP_PAUSE_T1, 1,  16'h0011, 0, 0, 0);
        addVec(OP_T1,       9,  16'h0020, 0, 0, 0);
        addVec(OP_CLR_T1,   1,  16'h0000, 0, 0, 0);
        addVec(OP_PAUSE,    1,  16'h0000, 1, 0, 0);
        addVec(OP_ADJ_ON,   1,  16'h0000, 1, 0, 0);
        addVec(OP_T2,       12, 16'h1200, 1, 0, 0);
        addVec(OP_SEL1,     1,  16'h1200, 1, 0, 0);
        addVec(OP_T2,       34, 16'h1234, 1, 0, 0);
        addVec(OP_ADJ_OFF,  1,  16'h1234, 1, 0, 0);
        addVec(OP_T1,       1,  16'h1234, 1, 0, 0);
        addVec(OP_ADJ_ON,   1,  16'h1234, 1, 0, 0);
        addVec(OP_BLINK1,   1,  16'h1234, 1, 0, 1);

        bus.clk1_lvl = 1'b0; bus.clk2_lvl = 1'b0; bus.blink_lvl = 1'b0;
        bus.pause_btn = 1'b0; bus.clr_btn = 1'b0; bus.adj_sw = 1'b0; bus.sel_sw = 1'b0;
        reset = 1'b1;
        cycles(3);
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b0});
        checkOutput("reset");
        reset = 1'b0;
        cycles(2);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].rep) applyStimulus(vecs[i].op);
            sb.push_back('{vecs[i].digits, vecs[i].paused, vecs[i].bmin, vecs[i].bsec});
            checkOutput($sformatf("vec%0d", i));
        end

        // Reset lands mid-cycle; outputs must clear before the next rising edge.
        #2 reset = 1'b1;
        #1;
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b0});
        checkOutput("async_reset");
        bus.adj_sw = 1'b0; bus.blink_lvl = 1'b0; bus.sel_sw = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(2);

        bus.clk1_lvl = 1'b1;
        cycles(1);
        sb.push_back('{16'h0000, 1'b0, 1'b0, 1'b0});
        checkOutput("tick_lat1");
        cycles(1);
        sb.push_back('{16'h0001, 1'b0, 1'b0, 1'b0});
        checkOutput("tick_lat2");
        bus.clk1_lvl = 1'b0;
        cycles(4);

        bus.pause_btn = 1'b1;
        cycles(SYNC_STAGES);
        sb.push_back('{16'h0001, 1'b0, 1'b0, 1'b0});
        checkOutput("pause_lat_early");
        cycles(1);
        sb.push_back('{16'h0001, 1'b1, 1'b0, 1'b0});
        checkOutput("pause_lat");
        bus.pause_btn = 1'b0;
        cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
